gmii_tx_framer: RTL and testbench

Synthesizable Ethernet transmit framer that converts a byte stream (valid/ready/last) into GMII or MII transmit signalling. It generates the inter-frame gap, preamble, SFD, minimum-length padding and FCS, and flags underruns with TX_ER. It sits in front of the TSU on the transmit path, which it feeds directly, and it provides the SFD pulse that PTP timestamping uses.

---
 rtl/gmii_tx_framer_pkg.sv | 34 +++
 rtl/gmii_tx_framer_crc.sv | 32 +++
 rtl/gmii_tx_framer.sv | 202 ++++++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_tx_framer_pkg.sv
// Shared constants, state encoding and CRC helper for the GMII transmit framer.
// The CRC helper is byte-wide and reflected so the RX checker can reuse it.
package gmii_tx_framer_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_POLY_REFL = {<<{CRC_POLY}};
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG
  } state_t;

  function automatic logic [31:0] crc32_byte(
    input logic [31:0] crc,
    input logic [7:0]  data
  );
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/gmii_tx_framer_crc.sv
// Byte-wide reflected CRC-32 accumulator: combinational next value, registered state.
// clr has priority over en; the register holds the raw (uncomplemented) CRC.
module crc32_d8
  import gmii_tx_framer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_next;

  // next CRC after absorbing one byte
  always_comb begin
    crc_next = crc32_byte(crc, data);
  end

  // CRC state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// Byte-stream to GMII/MII transmit framer: preamble, SFD, pad, FCS, IFG, underrun abort.
// Outputs are registered, so the line lags the internal state by one clock.
module gmii_tx_framer
  import gmii_tx_framer_pkg::*;
#(
  parameter int IFG_BYTES      = 12,
  parameter int PREAMBLE_BYTES = 7,
  parameter int MII_MODE       = 0,
  parameter int PAD_EN         = 1,
  parameter int MIN_PAYLOAD    = 60,
  parameter int FCS_EN         = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        gmii_txctrl,
  output logic [7:0]  gmii_txdata,
  output logic        gmii_txerr,
  output logic        sfd_pulse,
  output logic [15:0] frame_cnt,
  output logic [15:0] underrun_cnt
);

  localparam bit          MII      = (MII_MODE != 0);
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_BYTES - 1);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);
  localparam logic [15:0] MIN_LEN  = 16'(MIN_PAYLOAD);

  state_t      state, nstate;
  logic        phase, ur, nur, discard, ndisc, slot_end;
  logic [15:0] cnt, ncnt, pay, npay;
  logic [7:0]  hold, obyte, crc_din;
  logic        octrl, oerr, crc_clr, crc_en, fr_inc, ur_inc;
  logic [31:0] crc, fcs;

  // In MII a byte slot spans two clocks; phase 1 is its last clock.
  assign slot_end = MII ? phase : 1'b1;
  assign fcs      = ~crc;
  assign in_ready = discard || (state == S_DATA && slot_end && !ur);

  crc32_d8 u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (crc_clr),
    .en   (crc_en),
    .data (crc_din),
    .crc  (crc)
  );

  function automatic state_t after_payload(input logic [15:0] n);
    if (PAD_EN != 0 && n < MIN_LEN) return S_PAD;
    if (FCS_EN != 0) return S_FCS;
    return S_IFG;
  endfunction

  // next-state, line byte and bookkeeping for the current slot
  always_comb begin
    nstate  = state;
    ncnt    = cnt;
    npay    = pay;
    nur     = ur;
    ndisc   = discard && !(in_valid && in_last);
    obyte   = 8'h00;
    octrl   = 1'b0;
    oerr    = 1'b0;
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    crc_din = 8'h00;
    fr_inc  = 1'b0;
    ur_inc  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (in_valid && !discard) begin
          nstate = S_PRE;
          ncnt   = '0;
        end
      end
      S_PRE: begin
        octrl   = 1'b1;
        obyte   = PREAMBLE_BYTE;
        crc_clr = 1'b1;
        if (slot_end) begin
          ncnt = cnt + 16'd1;
          if (cnt == PRE_LAST) begin
            nstate = S_SFD;
            ncnt   = '0;
          end
        end
      end
      S_SFD: begin
        octrl = 1'b1;
        obyte = SFD_BYTE;
        npay  = '0;
        if (slot_end) nstate = S_DATA;
      end
      S_DATA: begin
        octrl = 1'b1;
        if (ur || !in_valid) begin
          oerr   = 1'b1;
          nur    = 1'b1;
          ur_inc = !ur;
          if (slot_end) begin
            nstate = S_IFG;
            ncnt   = '0;
            nur    = 1'b0;
            ndisc  = 1'b1;
          end
        end else begin
          obyte = (MII && phase) ? hold : in_data;
          if (slot_end) begin
            crc_en  = 1'b1;
            crc_din = obyte;
            npay    = (pay == 16'hFFFF) ? pay : pay + 16'd1;
            if (in_last) begin
              nstate = after_payload(npay);
              ncnt   = '0;
              fr_inc = (nstate == S_IFG);
            end
          end
        end
      end
      S_PAD: begin
        octrl = 1'b1;
        if (slot_end) begin
          crc_en = 1'b1;
          npay   = pay + 16'd1;
          if (npay >= MIN_LEN) begin
            nstate = (FCS_EN != 0) ? S_FCS : S_IFG;
            ncnt   = '0;
            fr_inc = (FCS_EN == 0);
          end
        end
      end
      S_FCS: begin
        octrl = 1'b1;
        obyte = fcs[{cnt[1:0], 3'b000} +: 8];
        if (slot_end) begin
          ncnt = cnt + 16'd1;
          if (cnt[1:0] == 2'd3) begin
            nstate = S_IFG;
            ncnt   = '0;
            fr_inc = 1'b1;
          end
        end
      end
      S_IFG: begin
        if (slot_end) begin
          ncnt = cnt + 16'd1;
          if (cnt == IFG_LAST) begin
            ncnt   = '0;
            nstate = (in_valid && !discard) ? S_PRE : S_IDLE;
          end
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  // control state; hold captures the byte peeked on the first MII clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pay     <= '0;
      ur      <= 1'b0;
      discard <= 1'b0;
      phase   <= 1'b0;
      hold    <= '0;
    end else begin
      state   <= nstate;
      cnt     <= ncnt;
      pay     <= npay;
      ur      <= nur;
      discard <= ndisc;
      phase   <= MII && (state != S_IDLE) && !phase;
      if (state == S_DATA && !phase) hold <= in_data;
    end
  end

  // registered line outputs and frame counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gmii_txctrl  <= 1'b0;
      gmii_txdata  <= '0;
      gmii_txerr   <= 1'b0;
      sfd_pulse    <= 1'b0;
      frame_cnt    <= '0;
      underrun_cnt <= '0;
    end else begin
      gmii_txctrl <= octrl;
      gmii_txerr  <= oerr;
      gmii_txdata <= MII ? {4'h0, phase ? obyte[7:4] : obyte[3:0]} : obyte;
      sfd_pulse   <= (state == S_SFD) && slot_end;
      if (fr_inc) frame_cnt <= frame_cnt + 16'd1;
      if (ur_inc) underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: GMII, no-pad and MII instances share one stimulus.
// Each task drives a scenario and checks captured line bytes against a local frame model.
module tb_gmii_tx_framer;

  typedef byte unsigned bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  int          sel = 0;

  logic        vld [3];
  logic        rdy [3];
  logic        ctl [3];
  logic [7:0]  txd [3];
  logic        er  [3];
  logic        sfd [3];
  logic [15:0] fc  [3];
  logic [15:0] uc  [3];

  int n_cmp = 0;
  int n_bad = 0;

  bq_t cap;
  int  gaps[$];
  int  sfdt[$];
  int  cyc, nctl, nerr, nhi, last_hi, first_hi;
  bit  seen, prev;

  always #5 clk = ~clk;

  assign vld[0] = in_valid && (sel == 0);
  assign vld[1] = in_valid && (sel == 1);
  assign vld[2] = in_valid && (sel == 2);

  gmii_tx_framer #(.PAD_EN(1)) dut_g (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld[0]),
    .in_last(in_last), .in_ready(rdy[0]), .gmii_txctrl(ctl[0]),
    .gmii_txdata(txd[0]), .gmii_txerr(er[0]), .sfd_pulse(sfd[0]),
    .frame_cnt(fc[0]), .underrun_cnt(uc[0])
  );

  gmii_tx_framer #(.PAD_EN(0)) dut_np (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld[1]),
    .in_last(in_last), .in_ready(rdy[1]), .gmii_txctrl(ctl[1]),
    .gmii_txdata(txd[1]), .gmii_txerr(er[1]), .sfd_pulse(sfd[1]),
    .frame_cnt(fc[1]), .underrun_cnt(uc[1])
  );

  gmii_tx_framer #(.MII_MODE(1)) dut_mii (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld[2]),
    .in_last(in_last), .in_ready(rdy[2]), .gmii_txctrl(ctl[2]),
    .gmii_txdata(txd[2]), .gmii_txerr(er[2]), .sfd_pulse(sfd[2]),
    .frame_cnt(fc[2]), .underrun_cnt(uc[2])
  );

  // line monitor for the selected instance, sampled away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (ctl[sel]) begin
        if (!seen) first_hi = cyc;
        if (seen && !prev) gaps.push_back(cyc - last_hi - 1);
        seen = 1'b1;
        last_hi = cyc;
        nctl++;
        cap.push_back(txd[sel]);
      end
      prev = ctl[sel];
      if (er[sel]) nerr++;
      if (sfd[sel]) sfdt.push_back(cyc);
      if (sel == 2 && txd[2][7:4] != 4'h0) nhi++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bq_t mk_frame(bq_t pl, bit pad);
    bq_t f;
    bq_t body;
    logic [31:0] c;
    for (int i = 0; i < 7; i++) f.push_back(8'h55);
    f.push_back(8'hD5);
    body = pl;
    if (pad) while (body.size() < 60) body.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (body[i]) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ body[i][b]) c = (c >> 1) ^ 32'hEDB88320;
        else c = c >> 1;
      end
      f.push_back(body[i]);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
    return f;
  endfunction

  function automatic bq_t to_nibbles(bq_t q);
    bq_t n;
    foreach (q[i]) begin
      n.push_back(q[i] & 8'h0F);
      n.push_back(q[i] >> 4);
    end
    return n;
  endfunction

  function automatic int first_diff(bq_t a, bq_t b);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  function automatic int pick(bq_t q, int i);
    return (i >= 0 && i < q.size()) ? int'(q[i]) : -1;
  endfunction

  task automatic do_reset(input int s);
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 8'h00;
    rst = 1'b1;
    sel = s;
    @(negedge clk);
    cap.delete();
    gaps.delete();
    sfdt.delete();
    cyc = 0; nctl = 0; nerr = 0; nhi = 0;
    last_hi = 0; first_hi = 0; seen = 1'b0; prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // present a payload; drop >= 0 removes in_valid for one clock before that byte
  task automatic send(input bq_t pl, input int drop);
    int  i = 0;
    int  guard = 0;
    bit  dropped = 1'b0;
    bit  hs;
    while (i < pl.size()) begin
      guard++;
      if (guard > 4000) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: consumed %0d want %0d", i, pl.size());
        break;
      end
      @(negedge clk);
      if (i == drop && !dropped) begin
        in_valid = 1'b0;
        in_last = 1'b0;
        dropped = 1'b1;
        continue;
      end
      in_valid = 1'b1;
      in_data = pl[i];
      in_last = (i == pl.size() - 1);
      hs = rdy[sel];
      @(posedge clk);
      if (hs) i++;
    end
  endtask

  task automatic finish_frame(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel = 0;
    @(negedge clk);
    n_cmp++; if (ctl[0] !== 1'b0) begin n_bad++; $display("FAIL rst_txctrl: got %b want 0", ctl[0]); end
    n_cmp++; if (txd[0] !== 8'h00) begin n_bad++; $display("FAIL rst_txdata: got %h want 00", txd[0]); end
    n_cmp++; if (er[0] !== 1'b0) begin n_bad++; $display("FAIL rst_txerr: got %b want 0", er[0]); end
    n_cmp++; if (rdy[0] !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", rdy[0]); end
    n_cmp++; if (sfd[0] !== 1'b0) begin n_bad++; $display("FAIL rst_sfd: got %b want 0", sfd[0]); end
    n_cmp++; if (fc[0] !== 16'd0) begin n_bad++; $display("FAIL rst_frame_cnt: got %0d want 0", fc[0]); end
    n_cmp++; if (uc[0] !== 16'd0) begin n_bad++; $display("FAIL rst_underrun_cnt: got %0d want 0", uc[0]); end
  endtask

  task automatic test_gmii60();
    bq_t pl;
    bq_t e;
    int  d;
    do_reset(0);
    for (int i = 0; i < 60; i++) pl.push_back(8'(i));
    send(pl, -1);
    finish_frame(40);
    e = mk_frame(pl, 1'b1);
    d = first_diff(cap, e);
    n_cmp++;
    if (d != -1) begin
      n_bad++;
      $display("FAIL gmii60_bytes: at %0d got %0d want %0d (len %0d/%0d)", d, pick(cap, d), pick(e, d), cap.size(), e.size());
    end
    n_cmp++; if (nctl != 72) begin n_bad++; $display("FAIL gmii60_txen: got %0d want 72", nctl); end
    n_cmp++; if (fc[0] !== 16'd1) begin n_bad++; $display("FAIL gmii60_frame_cnt: got %0d want 1", fc[0]); end
    d = (sfdt.size() == 1) ? sfdt[0] - first_hi : -1;
    n_cmp++; if (d != 7) begin n_bad++; $display("FAIL gmii60_sfd_pos: got %0d want 7", d); end
  endtask

  task automatic test_nopad();
    bq_t pl;
    bq_t e;
    int  d;
    int  n;
    logic [31:0] f;
    do_reset(1);
    for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
    send(pl, -1);
    finish_frame(40);
    e = mk_frame(pl, 1'b0);
    d = first_diff(cap, e);
    n_cmp++;
    if (d != -1) begin
      n_bad++;
      $display("FAIL nopad_bytes: at %0d got %0d want %0d (len %0d/%0d)", d, pick(cap, d), pick(e, d), cap.size(), e.size());
    end
    n = cap.size();
    f = (n >= 4) ? {cap[n-1], cap[n-2], cap[n-3], cap[n-4]} : 32'h0;
    n_cmp++; if (f !== 32'hCBF43926) begin n_bad++; $display("FAIL nopad_fcs: got %h want cbf43926", f); end
    n_cmp++; if (nctl != 21) begin n_bad++; $display("FAIL nopad_txen: got %0d want 21", nctl); end
    n_cmp++; if (fc[1] !== 16'd1) begin n_bad++; $display("FAIL nopad_frame_cnt: got %0d want 1", fc[1]); end
  endtask

  task automatic test_pad();
    bq_t pl;
    bq_t e;
    int  d;
    do_reset(0);
    pl.push_back(8'hAB);
    send(pl, -1);
    finish_frame(100);
    e = mk_frame(pl, 1'b1);
    d = first_diff(cap, e);
    n_cmp++;
    if (d != -1) begin
      n_bad++;
      $display("FAIL pad_bytes: at %0d got %0d want %0d (len %0d/%0d)", d, pick(cap, d), pick(e, d), cap.size(), e.size());
    end
    n_cmp++; if (nctl != 72) begin n_bad++; $display("FAIL pad_txen: got %0d want 72", nctl); end
    n_cmp++; if (fc[0] !== 16'd1) begin n_bad++; $display("FAIL pad_frame_cnt: got %0d want 1", fc[0]); end
  endtask

  task automatic test_back_to_back();
    bq_t p1;
    bq_t p2;
    bq_t e;
    bq_t e2;
    int  d;
    do_reset(0);
    for (int i = 0; i < 60; i++) begin
      p1.push_back(8'(i));
      p2.push_back(8'(8'h80 + i));
    end
    send(p1, -1);
    send(p2, -1);
    finish_frame(40);
    e = mk_frame(p1, 1'b1);
    e2 = mk_frame(p2, 1'b1);
    foreach (e2[i]) e.push_back(e2[i]);
    d = first_diff(cap, e);
    n_cmp++;
    if (d != -1) begin
      n_bad++;
      $display("FAIL b2b_bytes: at %0d got %0d want %0d (len %0d/%0d)", d, pick(cap, d), pick(e, d), cap.size(), e.size());
    end
    d = (gaps.size() > 0) ? gaps[0] : -1;
    n_cmp++; if (d != 12) begin n_bad++; $display("FAIL b2b_gap: got %0d want 12", d); end
    d = (sfdt.size() > 1) ? sfdt[1] - sfdt[0] : -1;
    n_cmp++; if (d != 84) begin n_bad++; $display("FAIL b2b_sfd_dist: got %0d want 84", d); end
    n_cmp++; if (fc[0] !== 16'd2) begin n_bad++; $display("FAIL b2b_frame_cnt: got %0d want 2", fc[0]); end
  endtask

  task automatic test_mii();
    bq_t pl;
    bq_t e;
    int  d;
    do_reset(2);
    for (int i = 0; i < 60; i++) pl.push_back(8'(i));
    send(pl, -1);
    finish_frame(60);
    e = to_nibbles(mk_frame(pl, 1'b1));
    d = first_diff(cap, e);
    n_cmp++;
    if (d != -1) begin
      n_bad++;
      $display("FAIL mii_nibbles: at %0d got %0d want %0d (len %0d/%0d)", d, pick(cap, d), pick(e, d), cap.size(), e.size());
    end
    n_cmp++; if (nctl != 144) begin n_bad++; $display("FAIL mii_txen: got %0d want 144", nctl); end
    n_cmp++; if (nhi != 0) begin n_bad++; $display("FAIL mii_upper_bits: got %0d want 0", nhi); end
    d = (sfdt.size() == 1) ? sfdt[0] - first_hi : -1;
    n_cmp++; if (d != 15) begin n_bad++; $display("FAIL mii_sfd_pos: got %0d want 15", d); end
    n_cmp++; if (fc[2] !== 16'd1) begin n_bad++; $display("FAIL mii_frame_cnt: got %0d want 1", fc[2]); end
  endtask

  task automatic test_underrun();
    bq_t p1;
    bq_t p2;
    bq_t e;
    bq_t f1;
    bq_t f2;
    int  d;
    do_reset(0);
    for (int i = 0; i < 12; i++) p1.push_back(8'(8'hC0 + i));
    for (int i = 0; i < 60; i++) p2.push_back(8'(8'h40 + i));
    send(p1, 10);
    n_cmp++; if (fc[0] !== 16'd0) begin n_bad++; $display("FAIL ur_frame_cnt_held: got %0d want 0", fc[0]); end
    send(p2, -1);
    finish_frame(40);
    f1 = mk_frame(p1, 1'b1);
    for (int i = 0; i < 18; i++) e.push_back(f1[i]);
    e.push_back(8'h00);
    f2 = mk_frame(p2, 1'b1);
    foreach (f2[i]) e.push_back(f2[i]);
    d = first_diff(cap, e);
    n_cmp++;
    if (d != -1) begin
      n_bad++;
      $display("FAIL ur_bytes: at %0d got %0d want %0d (len %0d/%0d)", d, pick(cap, d), pick(e, d), cap.size(), e.size());
    end
    n_cmp++; if (nerr != 1) begin n_bad++; $display("FAIL ur_txerr_slots: got %0d want 1", nerr); end
    d = (gaps.size() > 0) ? gaps[0] : -1;
    n_cmp++; if (d != 12) begin n_bad++; $display("FAIL ur_gap: got %0d want 12", d); end
    n_cmp++; if (uc[0] !== 16'd1) begin n_bad++; $display("FAIL ur_underrun_cnt: got %0d want 1", uc[0]); end
    n_cmp++; if (fc[0] !== 16'd1) begin n_bad++; $display("FAIL ur_frame_cnt: got %0d want 1", fc[0]); end
  endtask

  task automatic test_reset_mid();
    bq_t pl;
    bq_t e;
    int  d;
    logic [11:0] o;
    do_reset(0);
    @(negedge clk);
    in_valid = 1'b1;
    in_last = 1'b0;
    in_data = 8'h77;
    repeat (25) @(negedge clk);
    n_cmp++; if (ctl[0] !== 1'b1) begin n_bad++; $display("FAIL mid_active: got %b want 1", ctl[0]); end
    rst = 1'b1;
    #1;
    o = {ctl[0], er[0], sfd[0], rdy[0], txd[0]};
    n_cmp++; if (o !== 12'h000) begin n_bad++; $display("FAIL mid_async_reset: got %h want 000", o); end
    do_reset(0);
    for (int i = 0; i < 60; i++) pl.push_back(8'(8'hF0 - i));
    send(pl, -1);
    finish_frame(40);
    e = mk_frame(pl, 1'b1);
    d = first_diff(cap, e);
    n_cmp++;
    if (d != -1) begin
      n_bad++;
      $display("FAIL mid_next_bytes: at %0d got %0d want %0d (len %0d/%0d)", d, pick(cap, d), pick(e, d), cap.size(), e.size());
    end
    n_cmp++; if (fc[0] !== 16'd1) begin n_bad++; $display("FAIL mid_frame_cnt: got %0d want 1", fc[0]); end
    n_cmp++; if (nerr != 0) begin n_bad++; $display("FAIL mid_txerr: got %0d want 0", nerr); end
  endtask

  initial begin
    test_reset();
    test_gmii60();
    test_nopad();
    test_pad();
    test_back_to_back();
    test_mii();
    test_underrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
